// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath: sequences the shared memory,
// ALU and register file, flags illegal opcodes and counts retired instructions.
//
// state    | meaning
// IDLE     | post-reset, all controls low
// FETCH    | read instruction at PC, PC <= PC+4 on completion
// DECODE   | read registers, precompute branch target into ALUOut
// EXEC_R   | rs1 op rs2 (funct decode)
// EXEC_I   | rs1 + imm (ADDI)
// MEM_ADDR | rs1 + imm effective address for LW/SW
// MEM_RD   | load data read
// MEM_WR   | store data write, retires on completion
// WB_ALU   | write ALUOut to rd, retires
// WB_MEM   | write MDR to rd, retires
// BRANCH   | compare rs1/rs2, take target on Zero, retires
// TRAP     | illegal opcode, parked until reset
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       Opcode,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             Branch,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        Branch     = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b10;
                case (Opcode)
                    OP_R:         state_d = S_EXEC_R;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_WB_ALU;
            end
            S_EXEC_I: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_WB_ALU: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_WB_MEM: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b01;
                ALUOp      = 2'b01;
                Branch     = 1'b1;
                PCSrc      = 1'b1;
                PCWrite    = Zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase

        // Sticky until reset; set on the edge that enters TRAP so it reads high from entry.
        illegal_d = illegal_q | (state_d == S_TRAP);
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, instr_done};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign illegal = illegal_q;
    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I datapath variant. It sequences a single shared instruction/data memory, the single ALU and the register file across FETCH/DECODE/EXECUTE/MEM/WB states.
- Supported opcodes: R-type (0110011), ADDI (0010011), LW (0000011), SW (0100011) and BEQ (1100011). Any other opcode traps.
- Also maintains a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- Opcode  in  7  opcode of the instruction register (IR); valid from DECODE onward.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  write request (SW only).
- IorD  out  1  memory address source. 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load IR.
- PCWrite  out  1  load PC.
- PCSrc  out  1  PC source. 0 = ALU result (PC+4), 1 = ALUOut (branch target).
- ALUSrcA  out  2  ALU operand A. 00 = PC, 01 = rs1, 10 = OldPC.
- ALUSrcB  out  2  ALU operand B. 00 = rs2, 01 = constant 4, 10 = immediate.
- ALUOp  out  2  00 = add, 01 = branch compare, 10 = R-type funct decode.
- RegWrite  out  1  register file write enable.
- MemtoReg  out  1  writeback source. 0 = ALUOut, 1 = MDR.
- Branch  out  1  high in the BRANCH state.
- illegal  out  1  sticky trap flag.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- instret  out  CNT_W  retired-instruction count.
- state  out  4  current state, for debug.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). Reset forces state=IDLE, illegal=0 and instret=0.
- IDLE: every output is 0. The FSM goes unconditionally to FETCH on the first edge after reset is released.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, TRAP=11.
- Outputs not listed for a state are 0.
- FETCH:
  - Outputs: mem_req=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00.
  - IRWrite=PCWrite=mem_ready (combinational, so they assert only in the completing cycle).
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=10, ALUSrcB=10, ALUOp=00 (precomputes the branch target).
  - Next state by Opcode: R-type -> EXEC_R, ADDI -> EXEC_I, LW/SW -> MEM_ADDR, BEQ -> BRANCH, other -> TRAP.
- EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10. Next state WB_ALU.
- EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next state WB_ALU.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_req=1, IorD=1. Waits for mem_ready, then goes to WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, IorD=1. Waits for mem_ready, then goes to FETCH and retires.
- WB_ALU: RegWrite=1, MemtoReg=0. Next state FETCH; retires.
- WB_MEM: RegWrite=1, MemtoReg=1. Next state FETCH; retires.
- BRANCH:
  - Outputs: ALUSrcA=01, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=1.
  - PCWrite=Zero (combinational).
  - Next state FETCH; retires whether or not the branch is taken.
- TRAP: illegal=1 from entry, held until reset. No writes, no retire. The FSM stays in TRAP.
- Memory handshake:
  - mem_req, mem_we and IorD stay constant from the first request cycle until mem_ready is sampled high.
  - mem_ready is ignored in every other state.
  - A zero-wait memory (mem_ready tied high) gives FETCH a single cycle.
- Retire: instr_done=1 in WB_ALU, WB_MEM, BRANCH, and MEM_WR when mem_ready=1. instret increments by 1 on the same edge.
- Counter: instret wraps from all-ones to 0 with no flag.
- Cycle counts with zero-wait memory: R-type/ADDI 4, LW 5, SW 4, BEQ 3.
- Reset mid-operation: asserting rst_n low in any state (including a pending memory request) drops every output to 0 immediately, with no wait for clk. Execution restarts at IDLE.

Test Plan:
- ADDI (Opcode=0010011), mem_ready=1 -> states 1,2,4,8,1; RegWrite=1 only in state 8; instret 0->1; instr_done pulses once.
- LW, mem_ready low for 3 cycles in both FETCH and MEM_RD -> mem_req held 4 cycles in each state; IRWrite=1 on exactly one cycle; WB_MEM asserts MemtoReg=1 and RegWrite=1; 11 cycles from FETCH to FETCH.
- SW, mem_ready=1 -> MEM_WR has mem_we=1 and IorD=1; RegWrite never asserts; instret increments on the MEM_WR exit edge.
- BEQ with Zero=1, then a second BEQ with Zero=0 -> PCWrite=1 and PCSrc=1 in BRANCH for the first only; instret +2 total.
- Opcode=1111111 -> TRAP; illegal=1 persists for 20 cycles with no memory or register activity; instret unchanged; recovery only through rst_n.
- rst_n pulled low mid-cycle during MEM_RD with mem_req=1 -> mem_req=0 before the next clk edge, state=0, instret=0; after release, IDLE lasts one cycle, then FETCH.
